shift_arbiter: RTL and testbench
================================

Name: shift_arbiter

Overview:
- Shares one combinational `shifter` instance (type 00 = left logical, 01 = right logical, 10 = right arithmetic) between two requesters: port 0 is the ALU shift path and port 1 is the load/store alignment path.
- Arbitration is round-robin with valid/ready handshakes on both request ports.
- The shifter result is registered into a one-entry response buffer, which has its own valid/ready handshake toward the writeback side.
- Throughput is one shift per cycle when the response side is not back-pressured.

Parameters:
TAG_W, 4, width of the opaque tag carried from each request to its response

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
req0_valid  input  1  requester 0 has a request
req0_ready  output  1  requester 0 request accepted this cycle
req0_type  input  2  shift type for requester 0
req0_data  input  32  operand for requester 0
req0_shamt  input  5  shift amount for requester 0
req0_tag  input  TAG_W  tag for requester 0
req1_valid, req1_ready, req1_type, req1_data, req1_shamt, req1_tag  same as port 0, for requester 1
rsp_valid  output  1  response buffer holds a result
rsp_ready  input  1  consumer takes the response
rsp_data  output  32  shift result
rsp_src  output  1  index of the requester that produced the result
rsp_tag  output  TAG_W  tag of that request
rsp_err  output  1  request used the illegal type 2'b11

Behaviour:
- Reset:
  - rst_n low asynchronously clears all outputs: rsp_valid=0, rsp_data=0, rsp_src=0, rsp_tag=0, rsp_err=0.
  - Priority pointer resets to 0, meaning requester 0 is preferred.
  - A result buffered before reset is discarded; no response is produced for it after release.
- State machine (two states):
  - EMPTY: rsp_valid=0.
  - FULL: rsp_valid=1.
  - EMPTY -> FULL on an accepted request.
  - FULL -> EMPTY on rsp_valid & rsp_ready with no request accepted in the same cycle.
  - FULL -> FULL when the buffer is drained and refilled in the same cycle, or when it is held.
- Space: can_accept = EMPTY | (rsp_valid & rsp_ready).
- Grant (combinational):
  - Only one requester valid: that requester is granted.
  - Both valid: the requester selected by the pointer is granted.
  - reqN_ready = grant==N & can_accept.
  - Ready depends on valid, but a requester's valid must not depend on its ready.
- Pointer: on an accepted request, the pointer moves to the other requester. Without an accepted request it holds.
- Datapath:
  - The granted request's type, data and shamt drive the shared shifter.
  - On acceptance, the following are registered at the next rising edge:
    - rsp_data = shifter output,
    - rsp_src = granted index,
    - rsp_tag = granted tag,
    - rsp_err = 0.
- Latency: a request accepted in cycle N appears with rsp_valid=1 in cycle N+1.
- Illegal type 2'b11: the request is accepted normally, but rsp_data=0 and rsp_err=1. The pointer advances as for any accepted request.
- Back-pressure: while rsp_valid & !rsp_ready, all rsp_* outputs hold stable and both reqN_ready are 0.
- Same-cycle drain and refill: the new result replaces the drained one. There is no bubble.
- Shift amount is 5 bits, so 0..31 is passed unmodified. A shamt of 0 returns the operand unchanged for all legal types.

Test Plan:
- Single left shift: after reset, req0 {type 00, data 1, shamt 31, tag 3} with rsp_ready=1 -> req0_ready=1 in the same cycle; next cycle rsp_valid=1, rsp_data=0x80000000, rsp_src=0, rsp_tag=3, rsp_err=0.
- Round-robin contention:
  - Stimulus: req0 {01, 0x2, 1} and req1 {10, 0x80000000, 31} held valid for 3 cycles, rsp_ready=1.
  - Grants go to requesters 0, 1, 0 in that order.
  - The successive responses are 0x1 (src 0), 0xFFFFFFFF (src 1), 0x1 (src 0).
- Back-pressure:
  - Stimulus: rsp_ready=0 with one response buffered and req1 valid.
  - For 4 cycles, req1_ready=0 and rsp_* outputs are unchanged.
  - Raising rsp_ready drains the buffer and accepts req1 in that same cycle; req1's result appears on the next cycle.
- Illegal type: req1 {11, 0x1234, 4, tag 9} -> next cycle rsp_data=0, rsp_err=1, rsp_src=1, rsp_tag=9. A following req0 {00, 0x1234, 4} -> rsp_data=0x12340, rsp_err=0.
- Reset mid-operation:
  - Stimulus: rsp_valid=1 held under rsp_ready=0, then rst_n pulsed low asynchronously mid-cycle.
  - rsp_valid and rsp_data go to 0 immediately.
  - After release with both requesters valid, requester 0 is granted first.
- shamt 0: req0 {10, 0xDEADBEEF, 0} -> rsp_data=0xDEADBEEF.

Source files
------------

// File: rtl/shift_arbiter_if.sv
// Request/response bundle for shift_arbiter.
// Two valid/ready request ports in, one valid/ready response port out.
interface shift_arbiter_if #(
  parameter int TAG_W = 4
) ();
  logic             req0_valid;
  logic             req0_ready;
  logic [1:0]       req0_type;
  logic [31:0]      req0_data;
  logic [4:0]       req0_shamt;
  logic [TAG_W-1:0] req0_tag;

  logic             req1_valid;
  logic             req1_ready;
  logic [1:0]       req1_type;
  logic [31:0]      req1_data;
  logic [4:0]       req1_shamt;
  logic [TAG_W-1:0] req1_tag;

  logic             rsp_valid;
  logic             rsp_ready;
  logic [31:0]      rsp_data;
  logic             rsp_src;
  logic [TAG_W-1:0] rsp_tag;
  logic             rsp_err;

  modport master (
    output req0_valid, req0_type, req0_data,
    output req0_shamt, req0_tag,
    input  req0_ready,
    output req1_valid, req1_type, req1_data,
    output req1_shamt, req1_tag,
    input  req1_ready,
    input  rsp_valid, rsp_data, rsp_src,
    input  rsp_tag, rsp_err,
    output rsp_ready
  );

  modport slave (
    input  req0_valid, req0_type, req0_data,
    input  req0_shamt, req0_tag,
    output req0_ready,
    input  req1_valid, req1_type, req1_data,
    input  req1_shamt, req1_tag,
    output req1_ready,
    output rsp_valid, rsp_data, rsp_src,
    output rsp_tag, rsp_err,
    input  rsp_ready
  );
endinterface

// File: rtl/shift_arbiter.sv
// Round-robin arbiter sharing one shifter between ALU (port 0) and LSU
// (port 1); result held in a one-entry response buffer. Ports: clk, rst_n, bus.
module shifter (
  input  logic [1:0]  i_type,
  input  logic [31:0] i_data,
  input  logic [4:0]  i_shamt,
  output logic [31:0] o_data,
  output logic        o_err
);
  always_comb begin
    o_data = '0;
    o_err  = 1'b0;
    unique case (i_type)
      2'b00: o_data = i_data << i_shamt;
      2'b01: o_data = i_data >> i_shamt;
      2'b10: o_data = $unsigned($signed(i_data) >>> i_shamt);
      default: o_err = 1'b1;
    endcase
  end
endmodule

module shift_arbiter #(
  parameter int TAG_W = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  shift_arbiter_if.slave       bus
);
  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic             r_ptr;
  logic [31:0]      r_data;
  logic             r_src;
  logic [TAG_W-1:0] r_tag;
  logic             r_err;

  logic             w_can_accept;
  logic             w_any;
  logic             w_gnt;
  logic             w_acc;
  logic [1:0]       w_type;
  logic [31:0]      w_data;
  logic [4:0]       w_shamt;
  logic [TAG_W-1:0] w_tag;
  logic [31:0]      w_sh_data;
  logic             w_sh_err;
  logic             w_rsp_valid;

  assign w_rsp_valid  = (r_state == FULL);
  assign w_can_accept = (r_state == EMPTY) |
                        (w_rsp_valid & bus.rsp_ready);
  assign w_any = bus.req0_valid | bus.req1_valid;

  // Pointer only matters when both ports contend.
  assign w_gnt = (bus.req0_valid & bus.req1_valid)
               ? r_ptr : bus.req1_valid;
  assign w_acc = w_any & w_can_accept;

  assign bus.req0_ready = bus.req0_valid & ~w_gnt & w_can_accept;
  assign bus.req1_ready = bus.req1_valid &  w_gnt & w_can_accept;

  assign w_type  = w_gnt ? bus.req1_type  : bus.req0_type;
  assign w_data  = w_gnt ? bus.req1_data  : bus.req0_data;
  assign w_shamt = w_gnt ? bus.req1_shamt : bus.req0_shamt;
  assign w_tag   = w_gnt ? bus.req1_tag   : bus.req0_tag;

  shifter u_shifter (
    .i_type  (w_type),
    .i_data  (w_data),
    .i_shamt (w_shamt),
    .o_data  (w_sh_data),
    .o_err   (w_sh_err)
  );

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      EMPTY: if (w_acc) w_state_nxt = FULL;
      FULL:  if (bus.rsp_ready && !w_acc)
               w_state_nxt = EMPTY;
      default: w_state_nxt = EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= EMPTY;
      r_ptr   <= 1'b0;
      r_data  <= '0;
      r_src   <= 1'b0;
      r_tag   <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_acc) begin
        r_ptr  <= ~w_gnt;
        r_data <= w_sh_data;
        r_src  <= w_gnt;
        r_tag  <= w_tag;
        r_err  <= w_sh_err;
      end
    end
  end

  assign bus.rsp_valid = w_rsp_valid;
  assign bus.rsp_data  = r_data;
  assign bus.rsp_src   = r_src;
  assign bus.rsp_tag   = r_tag;
  assign bus.rsp_err   = r_err;
endmodule

// File: tb/tb_shift_arbiter.sv
// Directed testbench for shift_arbiter.
// Vector table plus back-pressure and async-reset sequences.
module tb_shift_arbiter;
  logic clk;
  logic rst_n;
  int   n_chk;
  int   n_err;

  shift_arbiter_if #(.TAG_W(4)) bus ();

  shift_arbiter #(.TAG_W(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic        v0;
    logic [1:0]  t0;
    logic [31:0] d0;
    logic [4:0]  s0;
    logic [3:0]  g0;
    logic        v1;
    logic [1:0]  t1;
    logic [31:0] d1;
    logic [4:0]  s1;
    logic [3:0]  g1;
    logic        rr;
    logic        e_r0;
    logic        e_r1;
    logic        e_v;
    logic [31:0] e_d;
    logic        e_src;
    logic [3:0]  e_tag;
    logic        e_err;
  } vec_t;

  vec_t vt[13];

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic set0(input logic v, input logic [1:0] t,
                      input logic [31:0] d, input logic [4:0] s,
                      input logic [3:0] g);
    bus.req0_valid = v;
    bus.req0_type  = t;
    bus.req0_data  = d;
    bus.req0_shamt = s;
    bus.req0_tag   = g;
  endtask

  task automatic set1(input logic v, input logic [1:0] t,
                      input logic [31:0] d, input logic [4:0] s,
                      input logic [3:0] g);
    bus.req1_valid = v;
    bus.req1_type  = t;
    bus.req1_data  = d;
    bus.req1_shamt = s;
    bus.req1_tag   = g;
  endtask

  task automatic chk_rsp(input string nm, input logic [31:0] d,
                         input logic src, input logic [3:0] tag,
                         input logic err);
    chk({nm, ".valid"}, {31'd0, bus.rsp_valid}, 32'd1);
    chk({nm, ".data"}, bus.rsp_data, d);
    chk({nm, ".src"}, {31'd0, bus.rsp_src}, {31'd0, src});
    chk({nm, ".tag"}, {28'd0, bus.rsp_tag}, {28'd0, tag});
    chk({nm, ".err"}, {31'd0, bus.rsp_err}, {31'd0, err});
  endtask

  initial begin
    n_chk = 0;
    n_err = 0;
    rst_n = 1'b0;
    set0(1'b0, 2'b00, 32'h0, 5'd0, 4'h0);
    set1(1'b0, 2'b00, 32'h0, 5'd0, 4'h0);
    bus.rsp_ready = 1'b0;

    vt[0]  = '{1'b1, 2'b00, 32'h1, 5'd31, 4'h3,
               1'b0, 2'b00, 32'h0, 5'd0, 4'h0, 1'b1,
               1'b1, 1'b0, 1'b1, 32'h80000000, 1'b0, 4'h3, 1'b0};
    vt[1]  = '{1'b0, 2'b00, 32'h0, 5'd0, 4'h0,
               1'b1, 2'b01, 32'h100, 5'd4, 4'h5, 1'b1,
               1'b0, 1'b1, 1'b1, 32'h10, 1'b1, 4'h5, 1'b0};
    vt[2]  = '{1'b1, 2'b01, 32'h2, 5'd1, 4'h1,
               1'b1, 2'b10, 32'h80000000, 5'd31, 4'h2, 1'b1,
               1'b1, 1'b0, 1'b1, 32'h1, 1'b0, 4'h1, 1'b0};
    vt[3]  = '{1'b1, 2'b01, 32'h2, 5'd1, 4'h1,
               1'b1, 2'b10, 32'h80000000, 5'd31, 4'h2, 1'b1,
               1'b0, 1'b1, 1'b1, 32'hFFFFFFFF, 1'b1, 4'h2, 1'b0};
    vt[4]  = '{1'b1, 2'b01, 32'h2, 5'd1, 4'h1,
               1'b1, 2'b10, 32'h80000000, 5'd31, 4'h2, 1'b1,
               1'b1, 1'b0, 1'b1, 32'h1, 1'b0, 4'h1, 1'b0};
    vt[5]  = '{1'b0, 2'b00, 32'h0, 5'd0, 4'h0,
               1'b1, 2'b11, 32'h1234, 5'd4, 4'h9, 1'b1,
               1'b0, 1'b1, 1'b1, 32'h0, 1'b1, 4'h9, 1'b1};
    vt[6]  = '{1'b1, 2'b00, 32'h1234, 5'd4, 4'h6,
               1'b0, 2'b00, 32'h0, 5'd0, 4'h0, 1'b1,
               1'b1, 1'b0, 1'b1, 32'h12340, 1'b0, 4'h6, 1'b0};
    vt[7]  = '{1'b1, 2'b10, 32'hDEADBEEF, 5'd0, 4'h7,
               1'b0, 2'b00, 32'h0, 5'd0, 4'h0, 1'b1,
               1'b1, 1'b0, 1'b1, 32'hDEADBEEF, 1'b0, 4'h7, 1'b0};
    vt[8]  = '{1'b0, 2'b00, 32'h0, 5'd0, 4'h0,
               1'b1, 2'b00, 32'hF, 5'd0, 4'hA, 1'b1,
               1'b0, 1'b1, 1'b1, 32'hF, 1'b1, 4'hA, 1'b0};
    vt[9]  = '{1'b0, 2'b00, 32'h0, 5'd0, 4'h0,
               1'b0, 2'b00, 32'h0, 5'd0, 4'h0, 1'b1,
               1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 4'h0, 1'b0};
    vt[10] = '{1'b1, 2'b00, 32'hFFFFFFFF, 5'd31, 4'hF,
               1'b0, 2'b00, 32'h0, 5'd0, 4'h0, 1'b1,
               1'b1, 1'b0, 1'b1, 32'h80000000, 1'b0, 4'hF, 1'b0};
    vt[11] = '{1'b1, 2'b01, 32'h80000000, 5'd31, 4'h1,
               1'b0, 2'b00, 32'h0, 5'd0, 4'h0, 1'b1,
               1'b1, 1'b0, 1'b1, 32'h1, 1'b0, 4'h1, 1'b0};
    vt[12] = '{1'b0, 2'b00, 32'h0, 5'd0, 4'h0,
               1'b1, 2'b10, 32'h7FFFFFFF, 5'd31, 4'h2, 1'b1,
               1'b0, 1'b1, 1'b1, 32'h0, 1'b1, 4'h2, 1'b0};

    // Reset state
    #3;
    chk("rst.valid", {31'd0, bus.rsp_valid}, 32'd0);
    chk("rst.data", bus.rsp_data, 32'd0);
    chk("rst.err", {31'd0, bus.rsp_err}, 32'd0);
    #19 rst_n = 1'b1;
    @(posedge clk); #1;

    foreach (vt[i]) begin
      set0(vt[i].v0, vt[i].t0, vt[i].d0, vt[i].s0, vt[i].g0);
      set1(vt[i].v1, vt[i].t1, vt[i].d1, vt[i].s1, vt[i].g1);
      bus.rsp_ready = vt[i].rr;
      #3;
      chk($sformatf("v%0d.r0rdy", i),
          {31'd0, bus.req0_ready}, {31'd0, vt[i].e_r0});
      chk($sformatf("v%0d.r1rdy", i),
          {31'd0, bus.req1_ready}, {31'd0, vt[i].e_r1});
      @(posedge clk); #1;
      if (vt[i].e_v)
        chk_rsp($sformatf("v%0d", i), vt[i].e_d,
                vt[i].e_src, vt[i].e_tag, vt[i].e_err);
      else
        chk($sformatf("v%0d.valid", i),
            {31'd0, bus.rsp_valid}, 32'd0);
    end

    // Back-pressure: buffer a result, then stall req1
    set0(1'b1, 2'b00, 32'h3, 5'd2, 4'h4);
    set1(1'b0, 2'b00, 32'h0, 5'd0, 4'h0);
    bus.rsp_ready = 1'b1;
    #3;
    chk("bp.fill.r0rdy", {31'd0, bus.req0_ready}, 32'd1);
    @(posedge clk); #1;
    chk_rsp("bp.fill", 32'hC, 1'b0, 4'h4, 1'b0);
    set0(1'b0, 2'b00, 32'h0, 5'd0, 4'h0);
    set1(1'b1, 2'b01, 32'h100, 5'd8, 4'h5);
    bus.rsp_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      #3;
      chk($sformatf("bp%0d.r1rdy", k),
          {31'd0, bus.req1_ready}, 32'd0);
      @(posedge clk); #1;
      chk_rsp($sformatf("bp%0d", k), 32'hC, 1'b0, 4'h4, 1'b0);
    end
    bus.rsp_ready = 1'b1;
    #3;
    chk("bp.rel.r1rdy", {31'd0, bus.req1_ready}, 32'd1);
    @(posedge clk); #1;
    chk_rsp("bp.rel", 32'h1, 1'b1, 4'h5, 1'b0);

    // Asynchronous reset while a result is held
    set1(1'b0, 2'b00, 32'h0, 5'd0, 4'h0);
    bus.rsp_ready = 1'b0;
    #3;
    chk("ar.pre.valid", {31'd0, bus.rsp_valid}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("ar.valid", {31'd0, bus.rsp_valid}, 32'd0);
    chk("ar.data", bus.rsp_data, 32'd0);
    chk("ar.src", {31'd0, bus.rsp_src}, 32'd0);
    chk("ar.tag", {28'd0, bus.rsp_tag}, 32'd0);
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    chk("ar.post.valid", {31'd0, bus.rsp_valid}, 32'd0);
    set0(1'b1, 2'b00, 32'h1, 5'd4, 4'h1);
    set1(1'b1, 2'b00, 32'h2, 5'd4, 4'h2);
    bus.rsp_ready = 1'b1;
    #3;
    chk("ar.g0.r0rdy", {31'd0, bus.req0_ready}, 32'd1);
    chk("ar.g0.r1rdy", {31'd0, bus.req1_ready}, 32'd0);
    @(posedge clk); #1;
    chk_rsp("ar.g0", 32'h10, 1'b0, 4'h1, 1'b0);
    #3;
    chk("ar.g1.r1rdy", {31'd0, bus.req1_ready}, 32'd1);
    @(posedge clk); #1;
    chk_rsp("ar.g1", 32'h20, 1'b1, 4'h2, 1'b0);

    set0(1'b0, 2'b00, 32'h0, 5'd0, 4'h0);
    set1(1'b0, 2'b00, 32'h0, 5'd0, 4'h0);
    @(posedge clk); #1;
    $display("Simulation finished: %0d checks, %0d errors",
             n_chk, n_err);
    $finish;
  end
endmodule
